// File: rtl/truth_table_sweeper_if.sv
// Stimulus/capture bundle between the truth-table sweeper and its environment.
//   master : the sweeper (drives DUT inputs and status/result outputs)
//   slave  : the environment (drives start/abort and returns the DUT output)
//   start, abort          control inputs to the sweeper
//   dut_in1..dut_in3      row bits driven to the circuit under test
//   dut_out               circuit-under-test output
//   busy, done            sweep status
//   row_idx               current row {in1,in2,in3}
//   truth_table, unstable captured code and per-row instability flags
//   match                 captured code equals the expected code with no instability
interface truth_table_sweeper_if;
  logic       start;
  logic       abort;
  logic       dut_in1;
  logic       dut_in2;
  logic       dut_in3;
  logic       dut_out;
  logic       busy;
  logic       done;
  logic [2:0] row_idx;
  logic [7:0] truth_table;
  logic [7:0] unstable;
  logic       match;

  modport master (
    input  start, abort, dut_out,
    output dut_in1, dut_in2, dut_in3, busy, done, row_idx, truth_table, unstable, match
  );

  modport slave (
    output start, abort, dut_out,
    input  dut_in1, dut_in2, dut_in3, busy, done, row_idx, truth_table, unstable, match
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Drives a 3-input combinational circuit through all 8 input rows, lets each row settle,
// samples the circuit output several times per row and assembles an 8-bit truth-table code
// (bit 7-r holds the output for row r), flagging rows whose samples disagree.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    master side of truth_table_sweeper_if (control, DUT drive/capture, results)
module truth_table_sweeper #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned SAMPLES       = 2,
  parameter logic [7:0]  EXPECTED_TT   = 8'hCB,
  parameter int unsigned CNT_W         = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  truth_table_sweeper_if.master bus
);

  localparam int unsigned ROW_W = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_e;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLES - 1);
  localparam logic [ROW_W-1:0] ROW_LAST    = ROW_W'(7);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [ROW_W-1:0]   row_q,   row_d;
  logic               ref_q,   ref_d;
  logic [7:0]         tt_q,    tt_d;
  logic [7:0]         unst_q,  unst_d;
  logic               busy_q,  busy_d;
  logic               done_q,  done_d;
  logic               match_q, match_d;

  // Row r lands in bit 7-r, which for a 3-bit index is simply ~r.
  logic [ROW_W-1:0]   bit_idx;
  assign bit_idx = ~row_q;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
      ref_q   <= 1'b0;
      tt_q    <= '0;
      unst_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      ref_q   <= ref_d;
      tt_q    <= tt_d;
      unst_q  <= unst_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      match_q <= match_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    ref_d   = ref_q;
    tt_d    = tt_q;
    unst_d  = unst_q;
    done_d  = 1'b0;
    match_d = match_q;

    unique case (state_q)
      S_IDLE: begin
        // abort has priority over start while idle.
        if (bus.start && !bus.abort) begin
          state_d = S_SETTLE;
          row_d   = '0;
          cnt_d   = '0;
          tt_d    = '0;
          unst_d  = '0;
          match_d = 1'b0;
        end
      end

      S_SETTLE: begin
        if (bus.abort) begin
          state_d = S_IDLE;
          row_d   = '0;
          cnt_d   = '0;
          match_d = 1'b0;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = S_SAMPLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_SAMPLE: begin
        if (bus.abort) begin
          state_d = S_IDLE;
          row_d   = '0;
          cnt_d   = '0;
          match_d = 1'b0;
        end else begin
          // First sample is the reference; later ones are compared against it.
          if (cnt_q == '0) begin
            ref_d = bus.dut_out;
          end else if (bus.dut_out != ref_q) begin
            unst_d[bit_idx] = 1'b1;
          end

          if (cnt_q == SAMPLE_LAST) begin
            tt_d[bit_idx] = bus.dut_out;
            cnt_d         = '0;
            if (row_q == ROW_LAST) begin
              state_d = S_DONE;
              row_d   = '0;
              done_d  = 1'b1;
              match_d = (tt_d == EXPECTED_TT) && (unst_d == 8'h00);
            end else begin
              state_d = S_SETTLE;
              row_d   = row_q + ROW_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_SETTLE) || (state_d == S_SAMPLE);
  end

  // DUT inputs follow the row register, which is cleared whenever the sweep is not running.
  assign bus.dut_in1     = row_q[2];
  assign bus.dut_in2     = row_q[1];
  assign bus.dut_in3     = row_q[0];
  assign bus.row_idx     = row_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.truth_table = tt_q;
  assign bus.unstable    = unst_q;
  assign bus.match       = match_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper with default parameters, driving a gate model
// of the 0xCB circuit (or a constant / glitched output) back into the sweeper.
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  truth_table_sweeper_if bus ();

  truth_table_sweeper dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Output model: 0 = 0xCB gate netlist, 1 = tied 0, 2 = tied 1; glitch inverts it.
  int   mode;
  logic glitch;
  logic ma, mb, mc, model;

  always_comb begin
    ma    = bus.dut_in1;
    mb    = bus.dut_in2;
    mc    = bus.dut_in3;
    model = (~mb & ~(ma & mc)) | (ma & mb);
    if (mode == 1) model = 1'b0;
    if (mode == 2) model = 1'b1;
    bus.dut_out = model ^ glitch;
  end

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present start for exactly one edge; returns 1ns after that start edge.
  task automatic pulse_start();
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
  endtask

  // Counts edges until done is seen, bounded.
  task automatic wait_done(output int n);
    n = 0;
    while (bus.done !== 1'b1 && n < 200) begin
      tick(1);
      n++;
    end
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({bus.dut_in1, bus.dut_in2, bus.dut_in3, bus.busy, bus.done,
                bus.row_idx, bus.truth_table, bus.unstable, bus.match});
  endfunction

  int n;
  int done_seen;

  initial begin
    mode      = 0;
    glitch    = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    rst_n     = 1'b0;
    tick(3);
    check("reset_outputs", all_outs(), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);

    // 1: golden sweep of the 0xCB model
    pulse_start();
    check("busy_after_start", 32'(bus.busy), 32'h1);
    wait_done(n);
    check("latency", 32'(n), 32'd48);
    check("tt_cb", 32'(bus.truth_table), 32'hCB);
    check("unstable_cb", 32'(bus.unstable), 32'h00);
    check("match_cb", 32'(bus.match), 32'h1);
    check("idle_drive_at_done", 32'({bus.busy, bus.row_idx, bus.dut_in1, bus.dut_in2, bus.dut_in3}), 32'h0);
    tick(1);
    check("done_one_cycle", 32'(bus.done), 32'h0);
    // abort and start together while idle: stay idle, results held
    bus.abort = 1'b1;
    bus.start = 1'b1;
    tick(2);
    check("abort_wins_idle", 32'(bus.busy), 32'h0);
    check("results_held", 32'({bus.truth_table, bus.match}), 32'h197);
    bus.abort = 1'b0;
    bus.start = 1'b0;
    tick(1);

    // 2: constant outputs
    mode = 1;
    pulse_start();
    wait_done(n);
    check("tt_zero", 32'(bus.truth_table), 32'h00);
    check("match_zero", 32'(bus.match), 32'h0);
    tick(1);
    mode = 2;
    pulse_start();
    wait_done(n);
    check("tt_ones", 32'(bus.truth_table), 32'hFF);
    check("match_ones", 32'(bus.match), 32'h0);
    check("unstable_ones", 32'(bus.unstable), 32'h00);
    tick(1);

    // 3: row 5 reference sample inverted (row r samples at start edge + 6r+5, +6r+6)
    mode = 0;
    pulse_start();
    tick(34);
    glitch = 1'b1;
    tick(1);
    glitch = 1'b0;
    wait_done(n);
    check("glitch_latency", 32'(n), 32'd13);
    check("glitch_unstable", 32'(bus.unstable), 32'h04);
    check("glitch_tt", 32'(bus.truth_table), 32'hCB);
    check("glitch_match", 32'(bus.match), 32'h0);
    tick(1);

    // 4: abort 20 cycles after start (row 3 settling; rows 0..2 captured)
    pulse_start();
    tick(18);
    bus.abort = 1'b1;
    tick(1);
    bus.abort = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'h0);
    check("abort_dut_in", 32'({bus.dut_in1, bus.dut_in2, bus.dut_in3}), 32'h0);
    check("abort_match", 32'(bus.match), 32'h0);
    check("abort_partial_tt", 32'(bus.truth_table), 32'hC0);
    done_seen = 0;
    for (int i = 0; i < 60; i++) begin
      tick(1);
      if (bus.done === 1'b1 || bus.busy === 1'b1) done_seen++;
    end
    check("abort_no_done", 32'(done_seen), 32'h0);

    // 5: asynchronous reset during row 3
    pulse_start();
    tick(18);
    check("row3_before_reset", 32'(bus.row_idx), 32'h3);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", all_outs(), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
    pulse_start();
    wait_done(n);
    check("after_reset_latency", 32'(n), 32'd48);
    check("after_reset_tt", 32'(bus.truth_table), 32'hCB);
    check("after_reset_match", 32'(bus.match), 32'h1);
    tick(1);

    // 6: start held high; row walk, single sweep, re-accept the cycle after done
    bus.start = 1'b1;
    tick(1);
    for (int r = 0; r < 8; r++) begin
      check("row_idx_walk", 32'(bus.row_idx), 32'(r));
      check("dut_in_walk", 32'({bus.dut_in1, bus.dut_in2, bus.dut_in3}), 32'(r));
      tick(6);
    end
    check("held_done", 32'({bus.done, bus.busy}), 32'h2);
    tick(1);
    check("held_done_ignored", 32'({bus.done, bus.busy}), 32'h0);
    tick(1);
    check("held_restart", 32'(bus.busy), 32'h1);
    bus.start = 1'b0;
    wait_done(n);
    check("second_sweep_latency", 32'(n), 32'd48);
    check("second_sweep_tt", 32'(bus.truth_table), 32'hCB);
    tick(2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
